// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency req/ack
// instruction memory and presents one instruction to IF/ID, with a single skid entry.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic [1:0]        fsm_state
);

    // Handshake: mem_req_o stays high with mem_addr_o stable until the cycle
    // mem_ack_i=1; that edge completes the request. Downstream takes the
    // output on any edge where if_valid=1 and stall_i=0.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n;
    logic [ADDR_W-1:0] buf_pc, buf_pc_n;
    logic [INST_W-1:0] buf_inst, buf_inst_n;
    logic [ADDR_W-1:0] if_pc_n;
    logic [INST_W-1:0] if_inst_n;
    logic              if_valid_n;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] drop_pc;
    logic              consumed;
    logic              out_free;

    assign target     = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign pc_inc     = pc + ADDR_W'(4);
    assign drop_pc    = branch_flag_i ? target : pc;
    assign consumed   = if_valid && !stall_i;
    assign out_free   = !if_valid || consumed;

    assign mem_req_o  = ((state == FETCH) || (state == DROP)) && !rst;
    assign mem_addr_o = req_addr;
    assign fsm_state  = state;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        buf_pc_n   = buf_pc;
        buf_inst_n = buf_inst;
        if_pc_n    = if_pc;
        if_inst_n  = if_inst;
        if_valid_n = if_valid;
        case (state)
            FETCH: begin
                if (branch_flag_i && mem_ack_i) begin
                    pc_n       = target;
                    req_addr_n = target;
                    if_valid_n = 1'b0;
                end else if (branch_flag_i) begin
                    // Request to the old address is still in flight; keep it stable.
                    pc_n       = target;
                    if_valid_n = 1'b0;
                    state_n    = DROP;
                end else if (mem_ack_i && out_free) begin
                    if_pc_n    = req_addr;
                    if_inst_n  = mem_rdata_i;
                    if_valid_n = 1'b1;
                    pc_n       = pc_inc;
                    req_addr_n = pc_inc;
                end else if (mem_ack_i) begin
                    buf_pc_n   = req_addr;
                    buf_inst_n = mem_rdata_i;
                    pc_n       = pc_inc;
                    req_addr_n = pc_inc;
                    state_n    = HOLD;
                end else if (consumed) begin
                    if_valid_n = 1'b0;
                end
            end
            DROP: begin
                pc_n       = drop_pc;
                if_valid_n = 1'b0;
                if (mem_ack_i) begin
                    req_addr_n = drop_pc;
                    state_n    = FETCH;
                end
            end
            HOLD: begin
                if (branch_flag_i) begin
                    buf_pc_n   = '0;
                    buf_inst_n = '0;
                    pc_n       = target;
                    req_addr_n = target;
                    if_valid_n = 1'b0;
                    state_n    = FETCH;
                end else if (consumed) begin
                    if_pc_n    = buf_pc;
                    if_inst_n  = buf_inst;
                    if_valid_n = 1'b1;
                    state_n    = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_pc   <= '0;
            buf_inst <= '0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_addr_n;
            buf_pc   <= buf_pc_n;
            buf_inst <= buf_inst_n;
            if_pc    <= if_pc_n;
            if_inst  <= if_inst_n;
            if_valid <= if_valid_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, checked each cycle
// against a queue-based model of fetched-but-not-consumed instructions.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    // Model: instructions fetched but not yet taken, plus the address of the
    // request on the bus, the next address to fetch, and whether the bus
    // request is a stale one whose data must be thrown away.
    logic [31:0] held_pc[$];
    logic [31:0] held_inst[$];
    logic [31:0] m_req_addr;
    logic [31:0] m_fetch_addr;
    bit          m_drop;

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held_pc.delete();
        held_inst.delete();
        m_req_addr   = 32'h0;
        m_fetch_addr = 32'h0;
        m_drop       = 1'b0;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic cyc(input bit st, input bit br, input logic [31:0] tg, input bit ak,
                       input bit rs = 1'b0);
        bit          exp_req;
        bit          ak_eff;
        logic [31:0] rd;
        logic [31:0] tgt;
        exp_req = !rs && (held_pc.size() < 2);
        ak_eff  = ak && exp_req;
        rd      = $urandom;
        rst             = rs;
        stall_i         = st;
        branch_flag_i   = br;
        branch_target_i = tg;
        mem_ack_i       = ak_eff;
        mem_rdata_i     = rd;
        #1;
        chk("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) chk("mem_addr", mem_addr_o, m_req_addr);
        chk("if_valid", {31'b0, if_valid}, {31'b0, held_pc.size() > 0});
        if (held_pc.size() > 0) begin
            chk("if_pc", if_pc, held_pc[0]);
            chk("if_inst", if_inst, held_inst[0]);
        end
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else if (br) begin
            tgt = {tg[31:2], 2'b00};
            held_pc.delete();
            held_inst.delete();
            if (!exp_req || ak_eff) begin
                m_req_addr   = tgt;
                m_fetch_addr = tgt;
                m_drop       = 1'b0;
            end else begin
                m_fetch_addr = tgt;
                m_drop       = 1'b1;
            end
        end else begin
            if (held_pc.size() > 0 && !st) begin
                void'(held_pc.pop_front());
                void'(held_inst.pop_front());
            end
            if (ak_eff) begin
                if (m_drop) begin
                    m_drop     = 1'b0;
                    m_req_addr = m_fetch_addr;
                end else begin
                    held_pc.push_back(m_req_addr);
                    held_inst.push_back(rd);
                    m_fetch_addr = m_req_addr + 32'd4;
                    m_req_addr   = m_fetch_addr;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; stall_i = 0; branch_flag_i = 0; branch_target_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);

        // Single-cycle memory, back-to-back fetches.
        repeat (5) cyc(0, 0, 0, 1);

        // Three-cycle latency.
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        // Stall while a second ack arrives: skid buffer fills.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("hold_state", {30'b0, fsm_state}, 32'd2);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("resume_addr", mem_addr_o, 32'h10);
        // Branch against a pending request to 0x10.
        cyc(0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("drop_addr", mem_addr_o, 32'h10);
        cyc(0, 0, 0, 1);
        chk("redirect_addr", mem_addr_o, 32'h100);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // Branch to misaligned target while stalled with a full buffer.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 1, 32'h203, 0);
        chk("flush_addr", mem_addr_o, 32'h200);
        chk("flush_valid", {31'b0, if_valid}, 32'd0);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // Address wrap at the top of memory.
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 1);
        chk("wrap_addr", mem_addr_o, 32'h0);
        cyc(0, 0, 0, 0);
        // Reset in the middle of an outstanding request.
        cyc(0, 0, 0, 0, 1);
        chk("midrst_req", {31'b0, mem_req_o}, 32'd0);
        chk("midrst_valid", {31'b0, if_valid}, 32'd0);
        cyc(0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 6,
                $urandom,
                $urandom_range(0, 99) < 50,
                $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
